// File: rtl/p88_stream_loader.sv
// rtl/p88_stream_loader.sv - P88 (C8 section / CA start vector) stream loader; optional checksum record via P88_CHECKSUM_EN
module p88_stream_loader #(
  parameter int ADDR_W    = 20,
  parameter int LEN_W     = 16,
  parameter int VEC_AW    = 3,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              hold_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wr,
  output logic [VEC_AW-1:0] vec_addr,
  output logic [7:0]        vec_din,
  output logic              vec_wr,
  output logic              load_err,
  output logic [23:0]       bytes_loaded
);

  typedef enum logic [4:0] {
    S_IDLE, S_CMD, S_SEG_L, S_SEG_H, S_OFF_L, S_OFF_H, S_SKIP0, S_SKIP1,
    S_LEN_L, S_LEN_H, S_DATA, S_VSEG_L, S_VSEG_H, S_VOFF_L, S_VOFF_H,
    S_VEC, S_CSUM, S_ERR
  } state_t;

  localparam logic [3:0] WR_N = 4'(WR_CYCLES);

  state_t            r_state;
  logic              r_dl_q;
  logic              r_wait, r_hold, r_mem_wr, r_vec_wr, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mem_din, r_vec_din;
  logic [VEC_AW-1:0] r_vec_addr;
  logic [23:0]       r_bytes;
  logic [LEN_W-1:0]  r_len;
  logic [15:0]       r_seg;
  logic [7:0]        r_off_lo, r_off_hi, r_len_lo;
  logic [3:0]        r_wcnt;
  logic [2:0]        r_vidx;

  logic              w_acc, w_rise, w_fall;
  logic [15:0]       w_off, w_hdr_len;
  logic [20:0]       w_phys;
  logic [LEN_W-1:0]  w_len_new;
  logic [7:0]        w_vec_next;

  assign w_acc     = ioctl_wr && !r_wait && (r_state != S_IDLE);
  assign w_rise    = ioctl_download && !r_dl_q;
  assign w_fall    = !ioctl_download && r_dl_q;
  assign w_off     = {ioctl_dout, r_off_lo};
  assign w_phys    = {1'b0, r_seg, 4'b0000} + {5'b00000, w_off};
  assign w_hdr_len = {ioctl_dout, r_len_lo};
  assign w_len_new = LEN_W'(w_hdr_len);

  assign ioctl_wait   = r_wait;
  assign hold_reset   = r_hold;
  assign mem_addr     = r_addr;
  assign mem_din      = r_mem_din;
  assign mem_wr       = r_mem_wr;
  assign vec_addr     = r_vec_addr;
  assign vec_din      = r_vec_din;
  assign vec_wr       = r_vec_wr;
  assign load_err     = r_err;
  assign bytes_loaded = r_bytes;

  // Byte for the vector write following the one at index r_vidx (FAR JMP operand order)
  always_comb begin
    w_vec_next = r_seg[15:8];
    case (r_vidx)
      3'd0:    w_vec_next = r_off_lo;
      3'd1:    w_vec_next = r_off_hi;
      3'd2:    w_vec_next = r_seg[7:0];
      default: w_vec_next = r_seg[15:8];
    endcase
  end

`ifdef P88_CHECKSUM_EN
  logic [7:0] r_sum;

  // Running sum of every accepted byte since the download started
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)       r_sum <= '0;
    else if (w_rise) r_sum <= '0;
    else if (w_acc)  r_sum <= r_sum + ioctl_dout;
  end
`endif

  // Record parser, write strobe sequencing and download edge handling
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dl_q     <= 1'b0;
      r_wait     <= 1'b0;
      r_hold     <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_vec_wr   <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_mem_din  <= '0;
      r_vec_din  <= '0;
      r_vec_addr <= '0;
      r_bytes    <= '0;
      r_len      <= '0;
      r_seg      <= '0;
      r_off_lo   <= '0;
      r_off_hi   <= '0;
      r_len_lo   <= '0;
      r_wcnt     <= '0;
      r_vidx     <= '0;
    end else begin
      r_dl_q <= ioctl_download;
      if (w_fall) begin
        // Download ended: release the system and abort any write in flight
        r_hold   <= 1'b0;
        r_wait   <= 1'b0;
        r_mem_wr <= 1'b0;
        r_vec_wr <= 1'b0;
        r_state  <= S_IDLE;
      end else if (w_rise) begin
        r_hold  <= 1'b1;
        r_err   <= 1'b0;
        r_bytes <= '0;
        r_state <= S_CMD;
      end else begin
        case (r_state)
          S_CMD: if (w_acc) begin
            case (ioctl_dout)
              8'hC8: r_state <= S_SEG_L;
              8'hCA: r_state <= S_VSEG_L;
`ifdef P88_CHECKSUM_EN
              8'hCF: r_state <= S_CSUM;
`endif
              default: begin
                r_err   <= 1'b1;
                r_state <= S_ERR;
              end
            endcase
          end
          S_SEG_L: if (w_acc) begin r_seg[7:0]  <= ioctl_dout; r_state <= S_SEG_H; end
          S_SEG_H: if (w_acc) begin r_seg[15:8] <= ioctl_dout; r_state <= S_OFF_L; end
          S_OFF_L: if (w_acc) begin r_off_lo    <= ioctl_dout; r_state <= S_OFF_H; end
          S_OFF_H: if (w_acc) begin r_addr <= ADDR_W'(w_phys); r_state <= S_SKIP0; end
          S_SKIP0: if (w_acc) r_state <= S_SKIP1;
          S_SKIP1: if (w_acc) r_state <= S_LEN_L;
          S_LEN_L: if (w_acc) begin r_len_lo <= ioctl_dout; r_state <= S_LEN_H; end
          S_LEN_H: if (w_acc) begin
            r_len   <= w_len_new;
            r_state <= (w_len_new == '0) ? S_CMD : S_DATA;
          end
          S_DATA: begin
            if (r_mem_wr) begin
              // Last strobe cycle: advance pointers so the gap cycle sees the new address
              if (r_wcnt == 4'd1) begin
                r_mem_wr <= 1'b0;
                r_addr   <= r_addr + ADDR_W'(1);
                r_len    <= r_len - LEN_W'(1);
                if (r_bytes != 24'hFFFFFF) r_bytes <= r_bytes + 24'd1;
              end else begin
                r_wcnt <= r_wcnt - 4'd1;
              end
            end else if (r_wait) begin
              r_wait <= 1'b0;
              if (r_len == '0) r_state <= S_CMD;
            end else if (w_acc) begin
              r_mem_din <= ioctl_dout;
              r_mem_wr  <= 1'b1;
              r_wait    <= 1'b1;
              r_wcnt    <= WR_N;
            end
          end
          S_VSEG_L: if (w_acc) begin r_seg[7:0]  <= ioctl_dout; r_state <= S_VSEG_H; end
          S_VSEG_H: if (w_acc) begin r_seg[15:8] <= ioctl_dout; r_state <= S_VOFF_L; end
          S_VOFF_L: if (w_acc) begin r_off_lo    <= ioctl_dout; r_state <= S_VOFF_H; end
          S_VOFF_H: if (w_acc) begin
            // First vector byte is the FAR JMP opcode
            r_off_hi   <= ioctl_dout;
            r_vec_din  <= 8'hEA;
            r_vec_addr <= '0;
            r_vidx     <= 3'd0;
            r_vec_wr   <= 1'b1;
            r_wcnt     <= WR_N;
            r_wait     <= 1'b1;
            r_state    <= S_VEC;
          end
          S_VEC: begin
            if (r_vec_wr) begin
              if (r_wcnt == 4'd1) begin
                r_vec_wr   <= 1'b0;
                r_vec_addr <= r_vec_addr + VEC_AW'(1);
                if (r_vidx == 3'd4) begin
                  r_wait  <= 1'b0;
                  r_state <= S_CMD;
                end
              end else begin
                r_wcnt <= r_wcnt - 4'd1;
              end
            end else begin
              r_vidx    <= r_vidx + 3'd1;
              r_vec_din <= w_vec_next;
              r_vec_wr  <= 1'b1;
              r_wcnt    <= WR_N;
            end
          end
`ifdef P88_CHECKSUM_EN
          S_CSUM: if (w_acc) begin
            // r_sum already includes the 0xCF command byte; back it out
            if (ioctl_dout == (r_sum - 8'hCF)) begin
              r_state <= S_CMD;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_p88_stream_loader.sv
// tb/tb_p88_stream_loader.sv - scoreboard bench for p88_stream_loader (WR_CYCLES 1 and 3 instances)
module tb_p88_stream_loader;

  typedef struct {
    int addr;
    int data;
    int width;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;

  logic        dl_a[2];
  logic        wr_a[2];
  logic [7:0]  d_a[2];
  logic        wait_a[2], hold_a[2], mwr_a[2], vwr_a[2], err_a[2];
  logic [19:0] addr_a[2];
  logic [7:0]  mdin_a[2], vdin_a[2];
  logic [2:0]  vaddr_a[2];
  logic [23:0] bytes_a[2];

  logic        m_wait, m_hold, m_mwr, m_vwr, m_err;
  logic [19:0] m_addr;
  logic [7:0]  m_mdin, m_vdin;
  logic [2:0]  m_vaddr;
  logic [23:0] m_bytes;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] csum = 8'h00;
  wr_t  mq[$];
  wr_t  vq[$];

  always #5 clk = ~clk;

  p88_stream_loader #(.WR_CYCLES(1)) u1 (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl_a[0]), .ioctl_wr(wr_a[0]),
    .ioctl_dout(d_a[0]), .ioctl_wait(wait_a[0]), .hold_reset(hold_a[0]),
    .mem_addr(addr_a[0]), .mem_din(mdin_a[0]), .mem_wr(mwr_a[0]),
    .vec_addr(vaddr_a[0]), .vec_din(vdin_a[0]), .vec_wr(vwr_a[0]),
    .load_err(err_a[0]), .bytes_loaded(bytes_a[0])
  );

  p88_stream_loader #(.WR_CYCLES(3)) u3 (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl_a[1]), .ioctl_wr(wr_a[1]),
    .ioctl_dout(d_a[1]), .ioctl_wait(wait_a[1]), .hold_reset(hold_a[1]),
    .mem_addr(addr_a[1]), .mem_din(mdin_a[1]), .mem_wr(mwr_a[1]),
    .vec_addr(vaddr_a[1]), .vec_din(vdin_a[1]), .vec_wr(vwr_a[1]),
    .load_err(err_a[1]), .bytes_loaded(bytes_a[1])
  );

  assign m_wait  = wait_a[sel];
  assign m_hold  = hold_a[sel];
  assign m_mwr   = mwr_a[sel];
  assign m_vwr   = vwr_a[sel];
  assign m_err   = err_a[sel];
  assign m_addr  = addr_a[sel];
  assign m_mdin  = mdin_a[sel];
  assign m_vdin  = vdin_a[sel];
  assign m_vaddr = vaddr_a[sel];
  assign m_bytes = bytes_a[sel];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input int a, input int d, input int w);
    wr_t e;
    e.addr = a; e.data = d; e.width = w;
    mq.push_back(e);
  endtask

  task automatic push_vec(input int a, input int d, input int w);
    wr_t e;
    e.addr = a; e.data = d; e.width = w;
    vq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_wait_timeout"}, n, 0);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle("send");
    wr_a[sel] = 1'b1;
    d_a[sel]  = b;
    @(negedge clk);
    wr_a[sel] = 1'b0;
    csum = csum + b;
  endtask

  task automatic rise();
    dl_a[sel] = 1'b1;
    csum = 8'h00;
    @(negedge clk);
  endtask

  task automatic fall();
    dl_a[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic c8_hdr(input logic [15:0] seg, input logic [15:0] off, input logic [15:0] len);
    send(8'hC8);
    send(seg[7:0]); send(seg[15:8]);
    send(off[7:0]); send(off[15:8]);
    send(8'h00); send(8'h00);
    send(len[7:0]); send(len[15:8]);
  endtask

  // Scoreboard monitor: pops an expected write at each strobe rise, checks width at the fall
  initial begin
    logic pm, pv, hm, hv;
    int   wm, wv;
    wr_t  cm, cv;
    pm = 0; pv = 0; hm = 0; hv = 0; wm = 0; wv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pm = 0; pv = 0; hm = 0; hv = 0;
      end else begin
        if (m_mwr && m_vwr) chk("mem_vec_exclusive", 1, 0);
        if (m_mwr) begin
          if (!pm) begin
            if (mq.size() == 0) begin
              checks++; failures++;
              $display("FAIL mem_unexpected: write addr 0x%0h data 0x%0h, none expected", m_addr, m_mdin);
              hm = 0;
            end else begin
              cm = mq.pop_front();
              chk("mem_addr", int'(m_addr), cm.addr);
              chk("mem_din", int'(m_mdin), cm.data);
              hm = 1; wm = 1;
            end
          end else begin
            wm++;
            if (hm) chk("mem_addr_stable", int'(m_addr), cm.addr);
          end
        end else if (pm && hm) begin
          chk("mem_wr_width", wm, cm.width);
          hm = 0;
        end
        if (m_vwr) begin
          if (!pv) begin
            if (vq.size() == 0) begin
              checks++; failures++;
              $display("FAIL vec_unexpected: write addr %0d data 0x%0h, none expected", m_vaddr, m_vdin);
              hv = 0;
            end else begin
              cv = vq.pop_front();
              chk("vec_addr", int'(m_vaddr), cv.addr);
              chk("vec_din", int'(m_vdin), cv.data);
              hv = 1; wv = 1;
            end
          end else begin
            wv++;
          end
        end else if (pv && hv) begin
          chk("vec_wr_width", wv, cv.width);
          hv = 0;
        end
        pm = m_mwr;
        pv = m_vwr;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int n;
    for (int i = 0; i < 2; i++) begin
      dl_a[i] = 1'b0; wr_a[i] = 1'b0; d_a[i] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", int'(m_hold), 0);
    chk("rst_wait", int'(m_wait), 0);
    chk("rst_mem_wr", int'(m_mwr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_addr", int'(m_addr), 0);
    chk("idle_bytes", int'(m_bytes), 0);
    chk("idle_err", int'(m_err), 0);

    // WR_CYCLES=1: section load
    sel = 0;
    rise();
    chk("hold_after_rise", int'(m_hold), 1);
    c8_hdr(16'h1000, 16'h0010, 16'd3);
    push_mem('h10010, 'hAA, 1); send(8'hAA);
    push_mem('h10011, 'hBB, 1); send(8'hBB);
    push_mem('h10012, 'hCC, 1); send(8'hCC);
    wait_idle("sec");
    chk("sec_bytes", int'(m_bytes), 3);
    chk("sec_hold", int'(m_hold), 1);
    chk("sec_err", int'(m_err), 0);

    // Start vector: FAR JMP 1234:5678
    push_vec(0, 'hEA, 1); push_vec(1, 'h78, 1); push_vec(2, 'h56, 1);
    push_vec(3, 'h34, 1); push_vec(4, 'h12, 1);
    send(8'hCA); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    n = 0;
    while (m_wait && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("vec_wait_cycles", n, 9);

    // Zero length section, then an unknown command
    c8_hdr(16'h2000, 16'h0000, 16'd0);
    send(8'h55);
    chk("bad_cmd_err", int'(m_err), 1);
    c8_hdr(16'h0000, 16'h0000, 16'd1);
    send(8'h66);
    repeat (3) @(negedge clk);
    chk("err_bytes", int'(m_bytes), 3);
    fall();
    chk("fall_hold", int'(m_hold), 0);
    rise();
    chk("rerise_err", int'(m_err), 0);
    chk("rerise_bytes", int'(m_bytes), 0);

`ifdef P88_CHECKSUM_EN
    c8_hdr(16'h0000, 16'h0020, 16'd1);
    push_mem('h00020, 'h5A, 1); send(8'h5A);
    s = csum;
    send(8'hCF); send(s);
    wait_idle("csum");
    chk("csum_ok_err", int'(m_err), 0);
    s = csum;
    send(8'hCF); send(s + 8'h01);
    chk("csum_bad_err", int'(m_err), 1);
    c8_hdr(16'h0000, 16'h0000, 16'd1);
    send(8'h77);
`else
    s = csum;
    send(8'hCF);
    chk("cf_unknown_err", int'(m_err), 1);
`endif
    fall();

    // WR_CYCLES=3: stretch, wrap, ignored strobes during wait
    sel = 1;
    rise();
    c8_hdr(16'hFFFF, 16'h0010, 16'd2);
    push_mem('h00000, 'h11, 3); send(8'h11);
    wr_a[1] = 1'b1; d_a[1] = 8'h99;
    n = 0;
    while (m_wait && n < 20) begin
      n++;
      @(negedge clk);
    end
    wr_a[1] = 1'b0;
    chk("data_wait_cycles", n, 4);
    push_mem('h00001, 'h22, 3); send(8'h22);
    wait_idle("wrap");
    chk("wrap_bytes", int'(m_bytes), 2);

    // Abort in the 2nd strobe cycle
    c8_hdr(16'h0000, 16'h0040, 16'd2);
    push_mem('h00040, 'h33, 2); send(8'h33);
    @(negedge clk);
    dl_a[1] = 1'b0;
    @(negedge clk);
    chk("abort_mem_wr", int'(m_mwr), 0);
    chk("abort_wait", int'(m_wait), 0);
    chk("abort_hold", int'(m_hold), 0);
    chk("abort_bytes", int'(m_bytes), 2);
    wr_a[1] = 1'b1; d_a[1] = 8'h44;
    repeat (4) @(negedge clk);
    wr_a[1] = 1'b0;
    repeat (4) @(negedge clk);

    // Async reset mid-record
    rise();
    c8_hdr(16'h0000, 16'h0080, 16'd1);
    push_mem('h00080, 'h44, 3); send(8'h44);
    wait_idle("pre_rst");
    chk("pre_rst_addr", int'(m_addr), 'h81);
    send(8'hC8); send(8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold", int'(m_hold), 0);
    chk("arst_addr", int'(m_addr), 0);
    chk("arst_din", int'(m_mdin), 0);
    chk("arst_bytes", int'(m_bytes), 0);
    chk("arst_wait", int'(m_wait), 0);
    dl_a[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("mem_queue_empty", mq.size(), 0);
    chk("vec_queue_empty", vq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p88_stream_loader.md
Name: p88_stream_loader

Overview:
- Parametrised successor to the inline P88 download parser in the Konix top level.
- Consumes the ioctl byte stream and decodes P88 records:
  - C8: data section, written to main RAM.
  - CA: start vector, written as a FAR JMP into the boot-vector ROM.
- Holds the system in reset while a download is active.
- Sits between the HPS ioctl interface and the RAM/ROM write ports. Memory write strobes are stretched for slow RAM models.

Parameters:
- ADDR_W, 20, width of the RAM write address; physical address = seg*16+off, truncated to ADDR_W.
- LEN_W, 16, width of the section length counter.
- VEC_AW, 3, width of the vector-ROM write address.
- WR_CYCLES, 1, number of cycles mem_wr/vec_wr stay high per byte (1..15).

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- ioctl_download, in, 1, download-active level from HPS.
- ioctl_wr, in, 1, byte strobe.
- ioctl_dout, in, 8, stream byte.
- ioctl_wait, out, 1, stall request to HPS.
- hold_reset, out, 1, system reset request while loading.
- mem_addr, out, ADDR_W, RAM write address.
- mem_din, out, 8, RAM write data.
- mem_wr, out, 1, RAM write strobe.
- vec_addr, out, VEC_AW, vector-ROM write address.
- vec_din, out, 8, vector-ROM write data.
- vec_wr, out, 1, vector-ROM write strobe.
- load_err, out, 1, sticky error flag, cleared at each download start.
- bytes_loaded, out, 24, count of data bytes written this download.

Behaviour:
- Reset: all outputs 0; state IDLE.
- Edge detection: ioctl_download is registered once.
  - Rising edge: hold_reset=1, load_err=0, bytes_loaded=0, state CMD, all in the same cycle.
  - Falling edge: hold_reset=0, ioctl_wait=0, mem_wr=0, vec_wr=0, state IDLE. This applies even mid-write; a write in progress is aborted.
- Byte acceptance: a byte is accepted on a cycle with ioctl_wr=1 && ioctl_wait=0 && state != IDLE. ioctl_wr is ignored at all other times.
- CMD state:
  - 0xC8 -> SEG_L.
  - 0xCA -> VSEG_L.
  - Any other byte -> ERR with load_err=1.
- ERR state: swallows all bytes until the download falls.
- C8 header: SEG_L, SEG_H, OFF_L, OFF_H, SKIP0, SKIP1, LEN_L, LEN_H (one byte each).
  - Address is loaded after OFF_H as {seg,4'b0}+off, truncated to ADDR_W.
  - LEN_W > 16: upper length bits are zero. LEN_W < 16: the header length is truncated to LEN_W bits.
  - After LEN_H: length 0 -> CMD immediately; otherwise -> DATA.
- DATA, for a byte accepted in cycle N:
  - mem_din latched.
  - mem_wr high cycles N+1..N+WR_CYCLES; mem_addr stable over those cycles.
  - ioctl_wait high cycles N+1..N+WR_CYCLES+1.
  - In cycle N+WR_CYCLES+1: addr+1 (wraps modulo 2^ADDR_W), length-1, bytes_loaded+1 (saturates at 2^24-1).
  - Next byte is acceptable from cycle N+WR_CYCLES+2.
  - When length reaches 0 -> CMD.
- CA record: VSEG_L, VSEG_H, VOFF_L, VOFF_H.
  - On VOFF_H acceptance, ioctl_wait goes high next cycle.
  - Five vector writes follow at vec_addr 0..4 with data EA, off_lo, off_hi, seg_lo, seg_hi.
  - Each write: vec_wr high for WR_CYCLES cycles, then one low gap cycle with the address advancing.
  - ioctl_wait drops in the gap cycle after the 5th write; state -> CMD.
- mem_wr and vec_wr are never high simultaneously.
- Download rising while already active has no effect.

Optional Feature:
- P88_CHECKSUM_EN
  - Defined:
    - An 8-bit running sum covers all accepted bytes from a download start, including command bytes.
    - Command 0xCF -> CSUM state; the next byte is compared against the sum taken before the 0xCF byte was added.
    - Mismatch -> load_err=1 and ERR. Match -> CMD.
  - Undefined:
    - 0xCF is an unknown command (ERR).
    - No sum logic is built.

Test Plan:
- Section load, WR_CYCLES=1: download rises; stream C8, seg 0x1000, off 0x0010, 2 skip bytes, len 3, data AA BB CC.
  - mem_wr pulses at addresses 0x10010, 0x10011, 0x10012 with AA/BB/CC.
  - bytes_loaded=3; state returns to CMD; hold_reset=1 throughout.
- Start vector: CA, seg 0x1234, off 0x5678.
  - vec_wr writes EA 78 56 34 12 to vec_addr 0..4.
  - ioctl_wait high continuously from the cycle after the last header byte until the gap after the 5th write.
- Stretch and wrap: WR_CYCLES=3, seg 0xFFFF, off 0x0010, len 2.
  - mem_wr is 3 cycles wide per byte.
  - Addresses 0x00000 and 0x00001 (wrap); ioctl_wait is 4 cycles per byte.
  - ioctl_wr strobes during wait are ignored.
- Zero length and bad command: C8 header with len 0, then 0x55.
  - No mem_wr; load_err=1; subsequent bytes produce no writes.
  - Next download rise clears load_err.
- Abort: download falls during the 2nd cycle of a WR_CYCLES=3 write.
  - Next cycle: mem_wr=0, ioctl_wait=0, hold_reset=0, state IDLE.
  - Async reset mid-record drives all outputs to 0 immediately.
- P88_CHECKSUM_EN: stream C8 header, data, then CF followed by the correct sum.
  - load_err stays 0; state returns to CMD.
  - Repeat with the sum+1: load_err=1 and state ERR.
